// File: rtl/mux_sweep_pkg.sv
// Shared types and constants for the mux4 self-test sequencer.
//   state_t    : sequencer states
//   VEC_W      : width of the sweep vector {s1,s0,i3,i2,i1,i0}
//   NUM_VEC    : number of vectors in one sweep
//   LAST_VEC   : final vector; reaching it ends the sweep
//   golden()   : expected mux4 output for a given vector
package mux_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned     VEC_W    = 6;
  localparam int unsigned     NUM_VEC  = 64;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  // Data bits in v[3:0], select in v[5:4].
  function automatic logic golden(input logic [VEC_W-1:0] v);
    logic [3:0] d;
    d = v[3:0];
    return d[v[5:4]];
  endfunction

endpackage

// File: rtl/mux_sweep_err_cnt.sv
// Saturating mismatch counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one mismatch; held at all-ones once reached
//   cnt        : current count
module mux_sweep_err_cnt
  import mux_sweep_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_sweep_ctrl.sv
// Self-test sequencer for the reference/generated mux4 pair. Sweeps all 64
// {s1,s0,i3..i0} vectors, lets each settle, then compares both mux outputs
// with the golden value and keeps a saturating mismatch count per mux.
//   start/busy/done     : sweep handshake (start honoured in IDLE or DONE)
//   mux_i, mux_s0/s1    : registered stimulus to both muxes
//   gf_out, bfg_out     : mux outputs, only looked at in SAMPLE
//   gf_err, bfg_err     : saturating mismatch counts, held until next start
// Optional (MUX_SWEEP_FIRST_FAIL_EN): first_fail_vec/first_fail_vld record
// the first vector on which either mux mismatched.
//
// state      | meaning
// ST_IDLE    | waiting for start after reset
// ST_SETTLE  | holding current vector while the muxes settle
// ST_SAMPLE  | one cycle: compare outputs, advance or finish
// ST_DONE    | sweep finished, results held, start re-arms
module mux_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       mux_i,
  output logic             mux_s0,
  output logic             mux_s1,
  input  logic             gf_out,
  input  logic             bfg_out,
  output logic [CNT_W-1:0] gf_err,
  output logic [CNT_W-1:0] bfg_err
`ifdef MUX_SWEEP_FIRST_FAIL_EN
  ,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_vld
`endif
);

  // The first vector settles one extra cycle, which puts done at
  // 64*(SETTLE_CYCLES+1)+1 edges after the accepting edge.
  localparam logic [7:0] SETTLE_LOAD_FIRST = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SETTLE_LOAD       = 8'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec;
  logic [7:0]       settle_cnt;
  logic             accept;
  logic             sample_en;
  logic             exp_val;
  logic             gf_miss, bfg_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (vec == LAST_VEC) ? ST_DONE : ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign sample_en = (state == ST_SAMPLE);
  assign exp_val   = golden(vec);
  assign gf_miss   = sample_en && (gf_out  != exp_val);
  assign bfg_miss  = sample_en && (bfg_out != exp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (accept) begin
      vec        <= '0;
      settle_cnt <= SETTLE_LOAD_FIRST;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (state == ST_SETTLE) begin
      if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
    end else if (sample_en) begin
      if (vec == LAST_VEC) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        vec        <= vec + 1'b1;
        settle_cnt <= SETTLE_LOAD;
      end
    end
  end

  assign mux_i  = vec[3:0];
  assign mux_s0 = vec[4];
  assign mux_s1 = vec[5];

  mux_sweep_err_cnt #(.CNT_W(CNT_W)) u_gf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (gf_miss),
    .cnt   (gf_err)
  );

  mux_sweep_err_cnt #(.CNT_W(CNT_W)) u_bfg_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (bfg_miss),
    .cnt   (bfg_err)
  );

`ifdef MUX_SWEEP_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (accept) begin
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if ((gf_miss || bfg_miss) && !first_fail_vld) begin
      first_fail_vec <= vec;
      first_fail_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
module tb_mux_sweep_ctrl;

  localparam int S_A = 2;
  localparam int S_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;

  logic       busy_a, done_a, s0_a, s1_a, gf_a, bfg_a;
  logic [3:0] i_a;
  logic [7:0] gf_err_a, bfg_err_a;
  logic       busy_b, done_b, s0_b, s1_b, gf_b, bfg_b;
  logic [3:0] i_b;
  logic [4:0] gf_err_b, bfg_err_b;
`ifdef MUX_SWEEP_FIRST_FAIL_EN
  logic [5:0] ffv_a, ffv_b;
  logic       ffl_a, ffl_b;
`endif

  // 0 ideal, 1 bfg stuck-at-0, 2 gf inverted, 3 bfg delayed two cycles
  int mode_a = 0;
  int mode_b = 0;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  function automatic logic mux_model(input logic [3:0] d, input logic s1, input logic s0);
    case ({s1, s0})
      2'b00:   return d[0];
      2'b01:   return d[1];
      2'b10:   return d[2];
      default: return d[3];
    endcase
  endfunction

  logic ideal_a, ideal_b, dly1_b, dly2_b;
  assign ideal_a = mux_model(i_a, s1_a, s0_a);
  assign ideal_b = mux_model(i_b, s1_b, s0_b);
  always @(posedge clk) begin
    dly1_b <= ideal_b;
    dly2_b <= dly1_b;
  end

  assign gf_a  = (mode_a == 2) ? ~ideal_a : ideal_a;
  assign bfg_a = (mode_a == 1) ? 1'b0 : ideal_a;
  assign gf_b  = (mode_b == 2) ? ~ideal_b : ideal_b;
  assign bfg_b = (mode_b == 3) ? dly2_b : ideal_b;

  mux_sweep_ctrl #(.SETTLE_CYCLES(S_A), .CNT_W(8)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_a),
    .busy    (busy_a),
    .done    (done_a),
    .mux_i   (i_a),
    .mux_s0  (s0_a),
    .mux_s1  (s1_a),
    .gf_out  (gf_a),
    .bfg_out (bfg_a),
    .gf_err  (gf_err_a),
    .bfg_err (bfg_err_a)
`ifdef MUX_SWEEP_FIRST_FAIL_EN
    ,
    .first_fail_vec (ffv_a),
    .first_fail_vld (ffl_a)
`endif
  );

  mux_sweep_ctrl #(.SETTLE_CYCLES(S_B), .CNT_W(5)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_b),
    .busy    (busy_b),
    .done    (done_b),
    .mux_i   (i_b),
    .mux_s0  (s0_b),
    .mux_s1  (s1_b),
    .gf_out  (gf_b),
    .bfg_out (bfg_b),
    .gf_err  (gf_err_b),
    .bfg_err (bfg_err_b)
`ifdef MUX_SWEEP_FIRST_FAIL_EN
    ,
    .first_fail_vec (ffv_b),
    .first_fail_vld (ffl_b)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Vector-order and hold-length monitor for dut_a.
  logic [5:0] prev_v;
  int         run_len = 0;
  bit         in_sweep = 1'b0;
  always @(negedge clk) begin
    logic [5:0] cur;
    int         exp_v;
    cur = {s1_a, s0_a, i_a};
    if (busy_a) begin
      if (!in_sweep || cur != prev_v) begin
        if (in_sweep)
          chk($sformatf("hold_len_v%0d", prev_v), run_len, (prev_v == 6'd0) ? S_A + 2 : S_A + 1);
        exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
        chk("vec_order", int'(cur), exp_v);
        run_len  = 1;
        in_sweep = 1'b1;
      end else begin
        run_len++;
      end
      prev_v = cur;
    end else begin
      in_sweep = 1'b0;
    end
  end

  task automatic push_sweep();
    sb_q.delete();
    for (int v = 0; v < 64; v++) sb_q.push_back(v);
  endtask

  // Pulse start, optionally re-pulse it ignore_at cycles later, and return
  // the number of edges from the accepting edge to done (-1 if none).
  task automatic run_sweep(input bit sel_b, input int ignore_at, output int done_edge,
                           output int acc_busy, output int acc_done, output int acc_errs);
    done_edge = -1;
    @(negedge clk);
    if (sel_b) start_b = 1'b1;
    else begin
      push_sweep();
      start_a = 1'b1;
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    acc_busy = sel_b ? int'(busy_b) : int'(busy_a);
    acc_done = sel_b ? int'(done_b) : int'(done_a);
    acc_errs = sel_b ? int'(gf_err_b) + int'(bfg_err_b) : int'(gf_err_a) + int'(bfg_err_a);
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (sel_b) start_b = (k == ignore_at);
      else       start_a = (k == ignore_at);
      if (sel_b ? done_b : done_a) begin
        done_edge = k;
        break;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int de, ab, ad, ae;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_vec", {s1_a, s0_a, i_a}, 0);
    chk("rst_gf_err", gf_err_a, 0);
    chk("rst_bfg_err", bfg_err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal muxes, default settle.
    mode_a = 0;
    run_sweep(1'b0, 0, de, ab, ad, ae);
    chk("ideal_done_edge", de, 193);
    chk("ideal_busy_after", busy_a, 0);
    chk("ideal_gf_err", gf_err_a, 0);
    chk("ideal_bfg_err", bfg_err_a, 0);
    chk("ideal_sb_drain", sb_q.size(), 0);
    chk("ideal_acc_busy", ab, 1);

    // bfg stuck at 0, with an ignored start mid-sweep.
    mode_a = 1;
    run_sweep(1'b0, 50, de, ab, ad, ae);
    chk("stuck_done_edge", de, 193);
    chk("stuck_gf_err", gf_err_a, 0);
    chk("stuck_bfg_err", bfg_err_a, 32);
    chk("stuck_sb_drain", sb_q.size(), 0);
`ifdef MUX_SWEEP_FIRST_FAIL_EN
    chk("stuck_ff_vec", ffv_a, 1);
    chk("stuck_ff_vld", ffl_a, 1);
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("hold_bfg_err", bfg_err_a, 32);
    chk("hold_done", done_a, 1);

    // Restart from DONE: results clear on the accepting edge.
    mode_a = 0;
    run_sweep(1'b0, 0, de, ab, ad, ae);
    chk("restart_acc_done", ad, 0);
    chk("restart_acc_busy", ab, 1);
    chk("restart_acc_errs", ae, 0);
    chk("restart_done_edge", de, 193);
    chk("restart_bfg_err", bfg_err_a, 0);
`ifdef MUX_SWEEP_FIRST_FAIL_EN
    chk("restart_ff_vld", ffl_a, 0);
`endif

    // Reset in the middle of a sweep.
    mode_a = 1;
    @(negedge clk);
    push_sweep();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("mid_bfg_err_nonzero", int'(bfg_err_a != 0), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_vec", {s1_a, s0_a, i_a}, 0);
    chk("arst_gf_err", gf_err_a, 0);
    chk("arst_bfg_err", bfg_err_a, 0);
`ifdef MUX_SWEEP_FIRST_FAIL_EN
    chk("arst_ff_vld", ffl_a, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_busy", busy_a, 0);
    chk("idle_done", done_a, 0);
    chk("idle_vec", {s1_a, s0_a, i_a}, 0);

    // Second instance: SETTLE_CYCLES=1, 5-bit counters.
    mode_b = 2;
    run_sweep(1'b1, 0, de, ab, ad, ae);
    chk("inv_done_edge", de, 129);
    chk("inv_gf_err_sat", gf_err_b, 31);
    chk("inv_bfg_err", bfg_err_b, 0);
`ifdef MUX_SWEEP_FIRST_FAIL_EN
    chk("inv_ff_vec", ffv_b, 0);
    chk("inv_ff_vld", ffl_b, 1);
`endif

    mode_b = 0;
    run_sweep(1'b1, 0, de, ab, ad, ae);
    chk("s1_ideal_done_edge", de, 129);
    chk("s1_ideal_gf_err", gf_err_b, 0);
    chk("s1_ideal_bfg_err", bfg_err_b, 0);

    mode_b = 3;
    run_sweep(1'b1, 0, de, ab, ad, ae);
    chk("dly_done_edge", de, 129);
    chk("dly_gf_err", gf_err_b, 0);
    chk("dly_bfg_err_nonzero", int'(bfg_err_b != 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
